mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 35 +++
 rtl/mem_port_arbiter.sv | 88 ++++++++
 tb/tb_mem_port_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch and data request ports plus the shared memory port.
interface mem_port_arbiter_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic              if_req;
    logic [AWIDTH-1:0] if_addr;
    logic              if_ready;
    logic              if_rvalid;
    logic [DWIDTH-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [2:0]        d_size;
    logic [AWIDTH-1:0] d_addr;
    logic [DWIDTH-1:0] d_wdata;
    logic              d_ready;
    logic              d_rvalid;
    logic [DWIDTH-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [2:0]        mem_size;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_wdata;
    logic [DWIDTH-1:0] mem_rdata;
    modport master (
        output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata,
        input  if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
               mem_en, mem_we, mem_size, mem_addr, mem_wdata
    );
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata,
        output if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
               mem_en, mem_we, mem_size, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data, data first with a starvation guard.
module mem_port_arbiter #(
    parameter int AWIDTH     = 32,
    parameter int DWIDTH     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam logic [3:0] SMAX   = 4'(STARVE_MAX);
    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);
    state_t            state, state_nx;
    logic [3:0]        starve_cnt, wait_cnt;
    logic              sel_if, we_q, grant_d, grant_if;
    logic [2:0]        size_q;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] wdata_q, if_rdata_q, d_rdata_q;

    // Grants are gated by rst so ready stays low while reset is asserted.
    always_comb begin
        grant_d  = 1'b0;
        grant_if = 1'b0;
        state_nx = state;
        case (state)
            IDLE: begin
                grant_d  = rst && bus.d_req && !(bus.if_req && starve_cnt == SMAX);
                grant_if = rst && bus.if_req && !grant_d;
                state_nx = (grant_d || grant_if) ? ISSUE : IDLE;
            end
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = (wait_cnt == '0) ? RESP : WAIT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
            wait_cnt   <= '0;
            sel_if     <= 1'b0;
            we_q       <= 1'b0;
            size_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (grant_d || grant_if) begin
                sel_if     <= grant_if;
                we_q       <= grant_d && bus.d_we;
                size_q     <= grant_d ? bus.d_size : 3'b010;
                addr_q     <= grant_d ? bus.d_addr : bus.if_addr;
                wdata_q    <= grant_d ? bus.d_wdata : '0;
                starve_cnt <= (grant_if || !bus.if_req) ? '0 :
                              (starve_cnt == SMAX) ? SMAX : starve_cnt + 4'd1;
            end
            if (state == ISSUE)                         wait_cnt <= LAT_M1;
            else if (state == WAIT && wait_cnt != '0)   wait_cnt <= wait_cnt - 4'd1;
            // Last WAIT cycle: memory data is valid, stores report zero.
            if (state == WAIT && wait_cnt == '0) begin
                if (sel_if) if_rdata_q <= bus.mem_rdata;
                else        d_rdata_q  <= we_q ? '0 : bus.mem_rdata;
            end
        end
    end

    assign bus.if_ready  = grant_if;
    assign bus.d_ready   = grant_d;
    assign bus.if_rvalid = state == RESP && sel_if;
    assign bus.d_rvalid  = state == RESP && !sel_if;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_en    = state == ISSUE;
    assign bus.mem_we    = state == ISSUE && we_q;
    assign bus.mem_size  = size_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign busy          = state != IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors with a grant/issue/response scoreboard.
module tb_mem_port_arbiter;
    typedef struct {
        logic        side;
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gap;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy0, busy1;
    logic [31:0] mem0;
    int cyc = 0;
    int n_vec = 0, n_bad = 0;
    txn_t exp_q[$];
    txn_t cur;
    logic pend = 1'b0;
    int t_g = 0, last_g = 0, t1 = 0, bn = 0, n1 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter_if #(.AWIDTH(32), .DWIDTH(32)) bus0 ();
    mem_port_arbiter_if #(.AWIDTH(32), .DWIDTH(32)) bus1 ();

    mem_port_arbiter #(.AWIDTH(32), .DWIDTH(32), .MEM_LAT(1), .STARVE_MAX(4))
        u0 (.clk(clk), .rst(rst), .bus(bus0), .busy(busy0));
    mem_port_arbiter #(.AWIDTH(32), .DWIDTH(32), .MEM_LAT(3), .STARVE_MAX(4))
        u1 (.clk(clk), .rst(rst), .bus(bus1), .busy(busy1));

    function automatic logic [31:0] f(input logic [31:0] a);
        return a == 32'h100 ? 32'hDEADBEEF : a ^ 32'h5A5A0000;
    endfunction

    // One-cycle-latency memory: read data is valid only in the cycle after mem_en.
    always @(posedge clk) mem0 <= (bus0.mem_en && !bus0.mem_we) ? f(bus0.mem_addr) : 32'hBAD00000 + 32'(cyc);
    assign bus0.mem_rdata = mem0;
    assign bus1.mem_rdata = 32'hC0DE0000 + 32'(cyc);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push(input logic side, input logic we, input logic [2:0] size,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input int gap);
        exp_q.push_back('{side, we, size, addr, wdata, rdata, gap});
    endfunction

    task automatic fetch(input logic [31:0] a);
        int i = 0;
        bus0.if_req = 1'b1;
        bus0.if_addr = a;
        do begin @(negedge clk); i++; end while (!bus0.if_ready && i < 60);
        if (!bus0.if_ready) check("fetch_wait_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus0.if_req = 1'b0;
    endtask

    task automatic data(input logic we, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int i = 0;
        bus0.d_req = 1'b1;
        bus0.d_we = we;
        bus0.d_size = sz;
        bus0.d_addr = a;
        bus0.d_wdata = wd;
        do begin @(negedge clk); i++; end while (!bus0.d_ready && i < 60);
        if (!bus0.d_ready) check("data_wait_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus0.d_req = 1'b0;
    endtask

    // Scoreboard monitor for the MEM_LAT=1 instance.
    always @(negedge clk) begin
        if (!rst) pend = 1'b0;
        else begin
            check("mem_we_outside_issue", 32'(bus0.mem_we && !bus0.mem_en), 32'd0);
            if (bus0.if_ready || bus0.d_ready) begin
                check("single_grant", 32'(bus0.if_ready && bus0.d_ready), 32'd0);
                if (exp_q.size() == 0) check("unexpected_grant", 32'd1, 32'd0);
                else begin
                    cur = exp_q.pop_front();
                    check("grant_side", 32'(bus0.if_ready), 32'(cur.side));
                    if (cur.gap != 0) check("grant_gap", 32'(cyc - last_g), 32'(cur.gap));
                    last_g = cyc;
                    t_g = cyc;
                    pend = 1'b1;
                end
            end
            if (bus0.mem_en) begin
                check("mem_en_pending", 32'(pend), 32'd1);
                check("mem_en_cycle", 32'(cyc), 32'(t_g + 1));
                check("mem_we", 32'(bus0.mem_we), 32'(cur.we));
                check("mem_size", 32'(bus0.mem_size), 32'(cur.size));
                check("mem_addr", bus0.mem_addr, cur.addr);
                if (cur.we) check("mem_wdata", bus0.mem_wdata, cur.wdata);
            end
            if (bus0.if_rvalid || bus0.d_rvalid) begin
                check("single_rvalid", 32'(bus0.if_rvalid && bus0.d_rvalid), 32'd0);
                check("rvalid_pending", 32'(pend), 32'd1);
                check("rvalid_cycle", 32'(cyc), 32'(t_g + 3));
                check("rvalid_side", 32'(bus0.if_rvalid), 32'(cur.side));
                check("rdata", cur.side ? bus0.if_rdata : bus0.d_rdata, cur.rdata);
                check("mem_addr_hold", bus0.mem_addr, cur.addr);
                pend = 1'b0;
            end
        end
    end

    // MEM_LAT=3 instance: latency, busy length and capture cycle.
    always @(negedge clk) begin
        if (rst) begin
            if (bus1.d_ready) begin t1 = cyc; bn = 0; end
            if (busy1) bn++;
            else if (bn != 0) begin check("lat3_busy_cycles", 32'(bn), 32'd5); bn = 0; end
            if (bus1.mem_en) check("lat3_mem_en_cycle", 32'(cyc), 32'(t1 + 1));
            if (bus1.d_rvalid) begin
                check("lat3_rvalid_cycle", 32'(cyc), 32'(t1 + 5));
                check("lat3_rdata", bus1.d_rdata, 32'hC0DE0000 + 32'(t1 + 4));
                n1++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int nd = 0;
        int i = 0;
        {bus0.if_req, bus0.d_req, bus0.d_we} = 3'b110;
        bus0.if_addr = 32'h0; bus0.d_size = 3'b0; bus0.d_addr = 32'h0; bus0.d_wdata = 32'h0;
        {bus1.if_req, bus1.d_req, bus1.d_we} = 3'b000;
        bus1.if_addr = 32'h0; bus1.d_size = 3'b010; bus1.d_addr = 32'h0; bus1.d_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_if_ready", 32'(bus0.if_ready), 32'd0);
        check("rst_d_ready", 32'(bus0.d_ready), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_mem_en", 32'(bus0.mem_en), 32'd0);
        check("rst_mem_addr", bus0.mem_addr, 32'd0);
        check("rst_d_rdata", bus0.d_rdata, 32'd0);
        bus0.if_req = 1'b0; bus0.d_req = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk); #1;

        // MEM_LAT=3 load on the second instance.
        bus1.d_req = 1'b1; bus1.d_addr = 32'h700;
        do begin @(negedge clk); i++; end while (!bus1.d_ready && i < 20);
        if (!bus1.d_ready) check("lat3_wait_timeout", 32'd0, 32'd1);
        @(posedge clk); #1 bus1.d_req = 1'b0;
        repeat (8) @(posedge clk); #1;

        // Fetch only.
        push(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        fetch(32'h100);
        repeat (5) @(posedge clk); #1;

        // Simultaneous store and fetch: data first, fetch four cycles later.
        push(1'b0, 1'b1, 3'b001, 32'h20, 32'h55, 32'h0, 0);
        push(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, f(32'h200), 4);
        fork
            data(1'b1, 3'b001, 32'h20, 32'h55);
            fetch(32'h200);
        join
        repeat (6) @(posedge clk); #1;

        // Both held: four data grants, one fetch, repeat; last two data grants with fetch idle.
        for (int k = 0; k < 4; k++) push(1'b0, 1'b0, 3'b010, 32'h1000 + 32'(4 * k), 32'h0, f(32'h1000 + 32'(4 * k)), k == 0 ? 0 : 4);
        push(1'b1, 1'b0, 3'b010, 32'h3000, 32'h0, f(32'h3000), 4);
        for (int k = 4; k < 8; k++) push(1'b0, 1'b0, 3'b010, 32'h1000 + 32'(4 * k), 32'h0, f(32'h1000 + 32'(4 * k)), 4);
        push(1'b1, 1'b0, 3'b010, 32'h3004, 32'h0, f(32'h3004), 4);
        for (int k = 8; k < 10; k++) push(1'b0, 1'b0, 3'b010, 32'h1000 + 32'(4 * k), 32'h0, f(32'h1000 + 32'(4 * k)), 4);
        fork
            for (int k = 0; k < 10; k++) data(1'b0, 3'b010, 32'h1000 + 32'(4 * k), 32'h0);
            for (int k = 0; k < 2; k++) fetch(32'h3000 + 32'(4 * k));
        join
        repeat (6) @(posedge clk); #1;

        // Data request raised and dropped while a fetch is in flight.
        push(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, f(32'h400), 0);
        fetch(32'h400);
        fork
            repeat (10) begin @(negedge clk); nd += int'(bus0.d_ready); end
            begin
                bus0.d_req = 1'b1; bus0.d_we = 1'b0; bus0.d_addr = 32'h800;
                repeat (2) @(posedge clk); #1;
                bus0.d_req = 1'b0;
            end
        join
        check("dropped_req_no_ready", 32'(nd), 32'd0);
        repeat (3) @(posedge clk); #1;

        // Reset during WAIT abandons the load; a fetch is accepted right after release.
        push(1'b0, 1'b0, 3'b010, 32'h500, 32'h0, f(32'h500), 0);
        push(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, f(32'h600), 0);
        data(1'b0, 3'b010, 32'h500, 32'h0);
        @(posedge clk); #1;
        check("pre_rst_in_wait", 32'(busy0 && !bus0.mem_en), 32'd1);
        rst = 1'b0;
        bus0.if_req = 1'b1; bus0.if_addr = 32'h600;
        #1;
        check("rst_mid_busy", 32'(busy0), 32'd0);
        check("rst_mid_if_ready", 32'(bus0.if_ready), 32'd0);
        check("rst_mid_mem_addr", bus0.mem_addr, 32'd0);
        check("rst_mid_mem_size", 32'(bus0.mem_size), 32'd0);
        check("rst_mid_d_rdata", bus0.d_rdata, 32'd0);
        check("rst_mid_if_rdata", bus0.if_rdata, 32'd0);
        check("rst_mid_rvalid", 32'(bus0.d_rvalid || bus0.if_rvalid), 32'd0);
        repeat (2) @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("first_cycle_after_release_ready", 32'(bus0.if_ready), 32'd1);
        @(posedge clk); #1 bus0.if_req = 1'b0;
        repeat (8) @(posedge clk); #1;

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("lat3_rvalid_count", 32'(n1), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
